// File: rtl/narnet_pkg.sv
// Shared defaults and fixed-point helpers for the NARNet arithmetic core.
// Word format is signed Q-format: N-bit two's complement with Q fractional bits.
package narnet_pkg;

  localparam int N_DEF = 16;
  localparam int Q_DEF = 10;
  localparam int L_DEF = 5;
  localparam int ONE   = 1 << Q_DEF;

  // Clamp a wide signed value into the signed range of a w-bit word; callers size-cast the result.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/narnet_mac_lane.sv
// One MAC neuron lane: saturating accumulator of (w*x)>>>Q plus a combinational
// biased, saturated output.
module narnet_mac_lane
  import narnet_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mac_clr,
  input  logic                mac_en,
  input  logic signed [N-1:0] w,
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] mac_out
);

  logic signed [N-1:0]   acc_reg;
  logic signed [N-1:0]   acc_next;
  logic signed [2*N-1:0] prod;

  // Full-width product; the arithmetic shift floors toward -inf with no rounding.
  always_comb begin
    prod     = (2*N)'(w) * (2*N)'(x);
    acc_next = N'(sat(64'(acc_reg) + 64'(prod >>> Q), N));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc_reg <= '0;
    else if (mac_clr) acc_reg <= '0;
    else if (mac_en)  acc_reg <= acc_next;
  end

  assign mac_out = N'(sat(64'(acc_reg) + 64'(b), N));

endmodule

// File: rtl/narnet_compute_core.sv
// NARNet arithmetic core: L parallel MAC lanes, a saturating running-sum register
// and a one-cycle registered tanh lookup, all in signed Q-format.
module narnet_compute_core
  import narnet_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF,
  parameter int L = L_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mac_clr,
  input  logic                mac_en,
  input  logic [L*N-1:0]      w_vec,
  input  logic [L*N-1:0]      x_vec,
  input  logic [L*N-1:0]      b_vec,
  output logic [L*N-1:0]      mac_out,
  input  logic                sum_clr,
  input  logic                sum_en,
  input  logic signed [N-1:0] sum_in,
  output logic signed [N-1:0] sum_out,
  input  logic signed [N-1:0] tanh_in,
  output logic signed [N-1:0] tanh_out
);

  // tanh(8.0) rounds to exactly 1.0 in any practical Q, so only |x| < 8.0 needs storage;
  // larger magnitudes reuse the last entry, which equals the saturated value.
  localparam int TANH_AW    = Q + 3;
  localparam int TANH_DEPTH = 1 << TANH_AW;
  localparam int ONE_Q      = 1 << Q;

  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    narnet_mac_lane #(.N(N), .Q(Q)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .mac_clr (mac_clr),
      .mac_en  (mac_en),
      .w       (w_vec[gi*N +: N]),
      .x       (x_vec[gi*N +: N]),
      .b       (b_vec[gi*N +: N]),
      .mac_out (mac_out[gi*N +: N])
    );
  end

  logic signed [N-1:0] sum_reg;
  logic signed [N-1:0] sum_next;

  assign sum_next = N'(sat(64'(sum_reg) + 64'(sum_in), N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sum_reg <= '0;
    else if (sum_clr) sum_reg <= '0;
    else if (sum_en)  sum_reg <= sum_next;
  end

  assign sum_out = sum_reg;

  // Non-negative table entry, rounded half away from zero (k >= 0 so +0.5 then truncate).
  function automatic logic signed [N-1:0] tanh_entry(input int k);
    real v;
    v = $tanh(real'(k) / real'(ONE_Q)) * real'(ONE_Q);
    return N'(sat(64'($rtoi(v + 0.5)), N));
  endfunction

  logic signed [N-1:0] tanh_rom [TANH_DEPTH];

  for (genvar gi = 0; gi < TANH_DEPTH; gi++) begin : g_rom
    assign tanh_rom[gi] = tanh_entry(gi);
  end

  // Odd symmetry: look up |x| and negate; -2^(N-1) lands in the saturated region.
  logic                tanh_neg;
  logic [N:0]          tanh_mag;
  logic [TANH_AW-1:0]  tanh_idx;

  always_comb begin
    tanh_neg = tanh_in[N-1];
    tanh_mag = tanh_neg ? ((N+1)'(0) - (N+1)'(tanh_in)) : (N+1)'(tanh_in);
    tanh_idx = (tanh_mag >= (N+1)'(TANH_DEPTH)) ? TANH_AW'(TANH_DEPTH - 1)
                                                : tanh_mag[TANH_AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tanh_out <= '0;
    else if (tanh_neg) tanh_out <= -tanh_rom[tanh_idx];
    else               tanh_out <= tanh_rom[tanh_idx];
  end

endmodule

// File: tb/tb_narnet_compute_core.sv
// Directed bench for narnet_compute_core: expectations are queued when stimulus is
// driven and compared against the DUT outputs one edge (or one settle) later.
module tb_narnet_compute_core;

  localparam int N = 16;
  localparam int Q = 10;
  localparam int L = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                mac_clr, mac_en;
  logic [L*N-1:0]      w_vec, x_vec, b_vec, mac_out;
  logic                sum_clr, sum_en;
  logic signed [N-1:0] sum_in, sum_out, tanh_in, tanh_out;

  always #5 clk = ~clk;

  narnet_compute_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mac_clr  (mac_clr),
    .mac_en   (mac_en),
    .w_vec    (w_vec),
    .x_vec    (x_vec),
    .b_vec    (b_vec),
    .mac_out  (mac_out),
    .sum_clr  (sum_clr),
    .sum_en   (sum_en),
    .sum_in   (sum_in),
    .sum_out  (sum_out),
    .tanh_in  (tanh_in),
    .tanh_out (tanh_out)
  );

  typedef struct {
    int                  kind;   // 0 mac_out lane, 1 sum_out, 2 tanh_out
    int                  lane;
    logic signed [N-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   acc_m[L];
  int   w_m[L];
  int   x_m[L];
  int   b_m[L];

  function automatic int sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int mac_step(int acc, int w, int x);
    longint p;
    p = longint'(w) * longint'(x);
    p = p >>> Q;
    return sat16(longint'(acc) + p);
  endfunction

  function automatic string kind_name(int k);
    case (k)
      0:       return "mac_out";
      1:       return "sum_out";
      default: return "tanh_out";
    endcase
  endfunction

  task automatic push(int kind, int lane, int v);
    exp_t e;
    e.kind = kind;
    e.lane = lane;
    e.val  = 16'(v);
    sb.push_back(e);
  endtask

  task automatic push_all_mac();
    for (int i = 0; i < L; i++) push(0, i, sat16(longint'(acc_m[i]) + longint'(b_m[i])));
  endtask

  task automatic check_pending();
    exp_t e;
    logic signed [N-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = mac_out[e.lane*N +: N];
        1:       obs = sum_out;
        default: obs = tanh_out;
      endcase
      n_assert++;
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s lane%0d observed=%0d expected=%0d", kind_name(e.kind), e.lane, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_pending();
  endtask

  task automatic settle();
    #1;
    check_pending();
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < L; i++) begin
      w_vec[i*N +: N] = 16'(w_m[i]);
      x_vec[i*N +: N] = 16'(x_m[i]);
      b_vec[i*N +: N] = 16'(b_m[i]);
    end
  endtask

  task automatic set_lane(int i, int w, int x, int b);
    w_m[i] = w;
    x_m[i] = x;
    b_m[i] = b;
  endtask

  task automatic mac_clear();
    mac_clr = 1'b1;
    for (int i = 0; i < L; i++) acc_m[i] = 0;
    push_all_mac();
    tick();
    mac_clr = 1'b0;
  endtask

  task automatic mac_pulse();
    mac_en = 1'b1;
    for (int i = 0; i < L; i++) acc_m[i] = mac_step(acc_m[i], w_m[i], x_m[i]);
    push_all_mac();
    tick();
    mac_en = 1'b0;
  endtask

  task automatic sum_op(logic clr, logic en, int v, int expv);
    sum_clr = clr;
    sum_en  = en;
    sum_in  = 16'(v);
    push(1, 0, expv);
    tick();
    sum_clr = 1'b0;
    sum_en  = 1'b0;
  endtask

  task automatic tanh_op(int v, int expv);
    tanh_in = 16'(v);
    push(2, 0, expv);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mac_clr = 1'b0; mac_en = 1'b0;
    sum_clr = 1'b0; sum_en = 1'b0; sum_in = '0; tanh_in = '0;
    for (int i = 0; i < L; i++) begin
      set_lane(i, 0, 0, 0);
      acc_m[i] = 0;
    end
    drive_lanes();

    // Reset state
    #2;
    push_all_mac();
    push(1, 0, 0);
    push(2, 0, 0);
    settle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single MAC: 0.5 + 1.0*2.0 = 2.5, then 4.5
    mac_clear();
    set_lane(0, 1024, 2048, 512);
    drive_lanes();
    push(0, 0, 512);
    settle();
    mac_pulse();
    push(0, 0, 2560);
    settle();
    mac_pulse();
    push(0, 0, 4608);
    settle();

    // Saturation at both rails, then clear-over-enable priority
    mac_clear();
    set_lane(0, 0, 0, 0);
    set_lane(1, 32767, 32767, 0);
    set_lane(2, 32767, -32768, 0);
    drive_lanes();
    for (int k = 0; k < 3; k++) begin
      mac_pulse();
      push(0, 1, 32767);
      push(0, 2, -32768);
      settle();
    end
    mac_clr = 1'b1;
    mac_en  = 1'b1;
    for (int i = 0; i < L; i++) acc_m[i] = 0;
    push(0, 1, 0);
    push(0, 2, 0);
    tick();
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    // Lane independence with random weights/inputs, an idle step and a mid-run bias change
    mac_clear();
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < L; i++)
        set_lane(i, int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096, b_m[i]);
      drive_lanes();
      if (s == 5) begin
        push_all_mac();
        tick();
      end else begin
        mac_pulse();
      end
      if (s == 8) begin
        for (int i = 0; i < L; i++) b_m[i] = int'($urandom_range(0, 4000)) - 2000;
        drive_lanes();
        push_all_mac();
        settle();
      end
    end

    // Running sum: saturation and clear-over-enable priority
    sum_op(1'b1, 1'b0, 0, 0);
    sum_op(1'b0, 1'b1, 100, 100);
    sum_op(1'b0, 1'b1, -300, -200);
    sum_op(1'b0, 1'b1, 32767, 32567);
    sum_op(1'b0, 1'b1, 5, 32572);
    sum_op(1'b1, 1'b0, 0, 0);
    sum_op(1'b0, 1'b1, 32767, 32767);
    sum_op(1'b0, 1'b1, 32767, 32767);
    sum_op(1'b1, 1'b1, 77, 0);
    sum_op(1'b0, 1'b1, -32768, -32768);
    sum_op(1'b0, 1'b1, -1, -32768);
    sum_op(1'b1, 1'b0, 0, 0);

    // tanh, one argument per cycle
    tanh_op(0, 0);
    tanh_op(1024, 780);
    tanh_op(-1024, -780);
    tanh_op(512, 473);
    tanh_op(32767, narnet_pkg::ONE);
    tanh_op(-32768, -narnet_pkg::ONE);
    tanh_op(2048, 987);
    tanh_op(4258, 1023);
    tanh_op(4259, 1024);
    tanh_op(-4259, -1024);
    tanh_op(-1, -1);

    // Asynchronous reset mid-accumulation
    mac_clear();
    for (int i = 0; i < L; i++) set_lane(i, 0, 0, 0);
    set_lane(0, 1024, 2048, 0);
    set_lane(3, 0, 0, 123);
    drive_lanes();
    mac_pulse();
    mac_pulse();
    push(0, 0, 4096);
    settle();
    sum_op(1'b0, 1'b1, 77, 77);
    tanh_op(1024, 780);
    rst_n = 1'b0;
    for (int i = 0; i < L; i++) acc_m[i] = 0;
    push_all_mac();
    push(0, 3, 123);
    push(1, 0, 0);
    push(2, 0, 0);
    settle();
    tanh_in = '0;
    #1;
    rst_n = 1'b1;
    set_lane(0, 1024, 2048, 512);
    set_lane(3, 0, 0, 0);
    drive_lanes();
    mac_pulse();
    push(0, 0, 2560);
    push(1, 0, 0);
    push(2, 0, 0);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
